// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use, taken-branch and multi-cycle MDU stall/flush control.
// Latency: outputs are combinational from state and current inputs; state advances each core clock.
// Backpressure: holds PC, IF/ID and ID/EX while an MDU op is outstanding or a load-use bubble is inserted.
module hazard_stall_ctrl #(
  parameter int RA_W    = 5,
  parameter int MDU_LAT = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_br_taken,
  input  logic              ex_md_start,
  input  logic              md_done,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_hold,
  output logic              ctrl_sel,
  output logic              exmem_bubble,
  output logic [PERF_W-1:0] stall_cycles
);

  // md_cnt must hold MDU_LAT-2; keep at least one bit when MDU_LAT==2
  localparam int CNT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_nxt;
  logic             lu_hz;
  logic             rs1_hit;
  logic             rs2_hit;

  // Load-use hazard: load in EX writes a register that ID reads; x0 never hazards
  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu_hz   = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

  // State and MDU countdown registers; reset aborts any outstanding MDU wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next-state: a taken branch suppresses an MDU start since EX is the branch itself
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      RUN: begin
        if (!ex_br_taken && ex_md_start) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_done || (md_cnt == '0)) begin
          state_nxt  = RUN;
          md_cnt_nxt = '0;
        end else begin
          md_cnt_nxt = md_cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt  = RUN;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode; everything forced low while reset is asserted
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    ctrl_sel     = 1'b0;
    exmem_bubble = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (ex_br_taken) begin
            // Squash the wrong-path fetch in IF/ID and the one in ID
            ifid_flush = 1'b1;
            ctrl_sel   = 1'b1;
          end else if (ex_md_start) begin
            // Start cycle already counts as a stall; EX stays put, MEM gets a bubble
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
          end else if (lu_hz) begin
            // One bubble into EX; the load reaches MEM next cycle and forwarding resolves it
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            ctrl_sel  = 1'b1;
          end
        end
        MD_BUSY: begin
          // ID/EX is frozen (not bubbled) so the MDU instruction stays in EX
          pc_hold      = 1'b1;
          ifid_hold    = 1'b1;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (pc_hold && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl against a cycle-level behavioural model.
// Latency: compares combinational outputs each cycle and the counter after each edge.
// Backpressure: n/a (bench drives every input directly).
module tb_hazard_stall_ctrl;

  localparam int RA_W    = 5;
  localparam int MDU_LAT = 4;

  logic            clk;
  logic            rst_n;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, ex_md_start, md_done;
  logic            pc_hold, ifid_hold, ifid_flush, idex_hold, ctrl_sel, exmem_bubble;
  logic [15:0]     stall_cycles;
  logic            s_pc_hold, s_ifid_hold, s_ifid_flush, s_idex_hold, s_ctrl_sel, s_exmem_bubble;
  logic [3:0]      stall4;
  logic [5:0]      obs;

  int tests = 0;
  int fails = 0;

  // model state: MDU busy flag, busy cycles elapsed, expected counters
  bit          m_busy;
  int          m_k;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;

  hazard_stall_ctrl #(.RA_W(RA_W), .MDU_LAT(MDU_LAT), .PERF_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .ex_md_start(ex_md_start), .md_done(md_done),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_hold(idex_hold),
    .ctrl_sel(ctrl_sel), .exmem_bubble(exmem_bubble), .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.RA_W(RA_W), .MDU_LAT(MDU_LAT), .PERF_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .ex_md_start(ex_md_start), .md_done(md_done),
    .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .ifid_flush(s_ifid_flush),
    .idex_hold(s_idex_hold), .ctrl_sel(s_ctrl_sel), .exmem_bubble(s_exmem_bubble),
    .stall_cycles(stall4)
  );

  assign obs = {pc_hold, ifid_hold, ifid_flush, idex_hold, ctrl_sel, exmem_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs {pc_hold, ifid_hold, ifid_flush, idex_hold, ctrl_sel, exmem_bubble}
  function automatic logic [5:0] exp_out();
    bit lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst_n)           return 6'b000000;
    if (m_busy)           return 6'b110101;
    if (ex_br_taken)      return 6'b001010;
    if (ex_md_start)      return 6'b110101;
    if (lu)               return 6'b110010;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_cnt = '0; m_cnt4 = '0;
  endtask

  // Advance the model across one rising edge using the inputs held during that cycle
  task automatic model_tick(input logic [5:0] e);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (e[5]) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    if (m_busy) begin
      m_k = m_k + 1;
      if (md_done || m_k >= MDU_LAT - 1) begin
        m_busy = 0;
        m_k = 0;
      end
    end else if (!ex_br_taken && ex_md_start) begin
      m_busy = 1;
      m_k = 0;
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
    ex_br_taken = 0; ex_md_start = 0; md_done = 0;
  endtask

  task automatic set_lu(input logic [RA_W-1:0] rd);
    ex_mem_read = 1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1;
    id_rs1 = 5'd7; id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    rst_n = 0;
    set_lu(5'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      e = exp_out();
      tests++;
      if (obs !== 6'b000000) begin
        fails++; $display("FAIL reset_outputs: got %b want 000000", obs);
      end
      tests++;
      if (stall_cycles !== 16'd0) begin
        fails++; $display("FAIL reset_stall: got %0d want 0", stall_cycles);
      end
      @(posedge clk); model_tick(e);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_load_use();
    logic [5:0] e;
    logic [15:0] base;
    base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      if (i == 0) set_lu(5'd5);
      if (i == 2) set_lu(5'd0);
      if (i == 2) id_rs2 = 5'd0;
      #1;
      e = exp_out();
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL load_use_c%0d: got %b want %b", i, obs, e);
      end
      tests++;
      if (obs !== ((i == 0) ? 6'b110010 : 6'b000000)) begin
        fails++; $display("FAIL load_use_pattern_c%0d: got %b", i, obs);
      end
      tests++;
      if (stall_cycles !== base + ((i == 0) ? 16'd0 : 16'd1)) begin
        fails++; $display("FAIL load_use_stall_c%0d: got %0d want %0d", i, stall_cycles,
                          base + ((i == 0) ? 16'd0 : 16'd1));
      end
      @(posedge clk); model_tick(e);
    end
  endtask

  task automatic test_branch_vs_hazard();
    logic [5:0] e;
    logic [15:0] base;
    base = m_cnt;
    @(negedge clk);
    clear_inputs();
    set_lu(5'd5);
    ex_br_taken = 1;
    ex_md_start = 1;
    #1;
    e = exp_out();
    tests++;
    if (obs !== 6'b001010) begin
      fails++; $display("FAIL branch_priority: got %b want 001010", obs);
    end
    @(posedge clk); model_tick(e);
    @(negedge clk);
    clear_inputs();
    #1;
    tests++;
    if (obs !== 6'b000000 || stall_cycles !== base) begin
      fails++; $display("FAIL branch_after: got %b/%0d want 000000/%0d", obs, stall_cycles, base);
    end
  endtask

  // Issue one MDU op; md_done on busy cycle done_at (0 = never); returns stalled cycles
  task automatic run_mdu(input int done_at, input string tag, output int nstall);
    logic [5:0] e;
    nstall = 0;
    for (int i = 0; i < MDU_LAT + 2; i++) begin
      @(negedge clk);
      clear_inputs();
      ex_md_start = (i == 0);
      md_done = (done_at != 0 && i == done_at);
      #1;
      e = exp_out();
      if (pc_hold) nstall++;
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL %s_c%0d: got %b want %b", tag, i, obs, e);
      end
      @(posedge clk); model_tick(e);
    end
  endtask

  task automatic test_mdu_full();
    int n;
    logic [15:0] base;
    base = m_cnt;
    run_mdu(0, "mdu_full", n);
    tests++;
    if (n != MDU_LAT) begin
      fails++; $display("FAIL mdu_full_len: got %0d want %0d", n, MDU_LAT);
    end
    #1;
    tests++;
    if (stall_cycles !== base + 16'(MDU_LAT)) begin
      fails++; $display("FAIL mdu_full_stall: got %0d want %0d", stall_cycles, base + 16'(MDU_LAT));
    end
  endtask

  task automatic test_mdu_early_and_reset();
    int n;
    logic [5:0] e;
    run_mdu(1, "mdu_early", n);
    tests++;
    if (n != 2) begin
      fails++; $display("FAIL mdu_early_len: got %0d want 2", n);
    end
    // new op, then async reset in its 2nd busy cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      ex_md_start = (i == 0);
      #1;
      e = exp_out();
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL mdu_pre_reset_c%0d: got %b want %b", i, obs, e);
      end
      if (i < 2) begin
        @(posedge clk); model_tick(e);
      end
    end
    rst_n = 0;
    model_reset();
    #1;
    tests++;
    if (obs !== 6'b000000 || stall_cycles !== 16'd0) begin
      fails++; $display("FAIL mdu_async_reset: got %b/%0d want 000000/0", obs, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    e = exp_out();
    tests++;
    if (obs !== 6'b000000 || obs !== e) begin
      fails++; $display("FAIL mdu_after_reset: got %b want 000000", obs);
    end
    @(posedge clk); model_tick(e);
  endtask

  task automatic test_saturation();
    logic [5:0] e;
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    ex_md_start = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      e = exp_out();
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL sat_c%0d: got %b want %b", i, obs, e);
      end
      @(posedge clk); model_tick(e);
      @(negedge clk);
    end
    ex_md_start = 0;
    tests++;
    if (stall4 !== 4'd15) begin
      fails++; $display("FAIL sat_perf4: got %0d want 15", stall4);
    end
    tests++;
    if (stall_cycles !== 16'd20) begin
      fails++; $display("FAIL sat_perf16: got %0d want 20", stall_cycles);
    end
  endtask

  task automatic test_random();
    logic [5:0] e;
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(0, 99) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 5) == 0);
      ex_md_start = ($urandom_range(0, 7) == 0);
      md_done     = ($urandom_range(0, 4) == 0);
      #1;
      if (!rst_n) model_reset();
      e = exp_out();
      tests++;
      if (obs !== e) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL rand_out_c%0d: got %b want %b", i, obs, e);
      end
      tests++;
      if (stall_cycles !== m_cnt || stall4 !== m_cnt4) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL rand_perf_c%0d: got %0d/%0d want %0d/%0d",
                                i, stall_cycles, stall4, m_cnt, m_cnt4);
      end
      tests++;
      if ((ifid_flush && ifid_hold) || (ctrl_sel && idex_hold)) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL rand_exclusive_c%0d: got %b want no conflicting enables", i, obs);
      end
      @(posedge clk); model_tick(e);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_load_use();
    test_branch_vs_hazard();
    test_mdu_full();
    test_mdu_early_and_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
